// File: rtl/wb_test_pkg.sv
// -----------------------------------------------------------------------------
// wb_test_pkg
// Shared definitions for the Wishbone test initiator:
//   - state_t        : initiator FSM states (IDLE / BUS / RESP)
//   - WB_ADR_W/DAT_W/SEL_W : Wishbone classic widths
//   - TIMEOUT_DEFAULT: default bus-cycle timeout, in clock cycles
//   - TMO_CNT_W      : width of the timeout counter (covers 1..255)
// -----------------------------------------------------------------------------
package wb_test_pkg;

    localparam int WB_ADR_W        = 32;
    localparam int WB_DAT_W        = 32;
    localparam int WB_SEL_W        = 4;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int TMO_CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wbi_timeout_ctr.sv
// -----------------------------------------------------------------------------
// wbi_timeout_ctr
// Counts cycles spent waiting for a Wishbone ack and flags the cycle in which
// the wait budget runs out.
//
// Parameters:
//   LIMIT   - number of waiting cycles allowed (1..255)
// Ports:
//   clk     in  1 : clock
//   rst     in  1 : asynchronous active-high reset
//   clear   in  1 : restart the count (issued with each new command)
//   enable  in  1 : a waiting cycle elapsed without ack
//   expire  out 1 : this waiting cycle is the LIMIT-th one
// -----------------------------------------------------------------------------
module wbi_timeout_ctr
    import wb_test_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(LIMIT - 1);

    logic [TMO_CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of waiting cycles already elapsed, so the edge
    // closing the LIMIT-th cycle is the one where cnt == LIMIT-1. The owner
    // leaves BUS on that edge, so cnt never needs to wrap.
    assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/wb_test_initiator.sv
// -----------------------------------------------------------------------------
// wb_test_initiator
// Wishbone classic single-transfer initiator. Accepts one command at a time on
// a valid/ready stream, runs one Wishbone read or write, and returns read data
// (or a timeout error) on a response stream held until accepted.
//
// Build option: define WB_TEST_INITIATOR_TIMEOUT_EN to enable the bus timeout.
// Without it BUS waits for ack indefinitely and rsp_err is constant 0.
//
// Parameters:
//   TIMEOUT_CYCLES - max cycles stb stays high awaiting ack (1..255)
//   CNT_W          - width of the completed-transfer counter
// Ports:
//   wb_clk_i, wb_rst_i         : clock, async active-high reset
//   cmd_valid/cmd_ready        : command handshake
//   cmd_we/adr/dat/sel         : command payload
//   rsp_valid/rsp_ready        : response handshake
//   rsp_dat/rsp_err            : read data (0 for writes/errors), timeout flag
//   txn_count                  : acked transfers, wraps
//   wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o : Wishbone master outputs
//   wbm_ack_i/dat_i            : Wishbone responder inputs
// -----------------------------------------------------------------------------
module wb_test_initiator
    import wb_test_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [WB_ADR_W-1:0] cmd_adr,
    input  logic [WB_DAT_W-1:0] cmd_dat,
    input  logic [WB_SEL_W-1:0] cmd_sel,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_dat,
    output logic                rsp_err,
    output logic [CNT_W-1:0]    txn_count,

    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [WB_DAT_W-1:0] wbm_dat_i
);

    state_t state;
    logic   cmd_fire;

    // Handshake signals are pure state decodes; cmd_ready is additionally
    // held low while reset is asserted so nothing is accepted in reset.
    assign cmd_ready = (state == IDLE) && !wb_rst_i;
    assign rsp_valid = (state == RESP);
    assign cmd_fire  = cmd_valid && cmd_ready;

`ifdef WB_TEST_INITIATOR_TIMEOUT_EN
    logic tmo_expire;

    // Counts only BUS cycles without ack, so an ack on the expiring cycle
    // wins: expire is never raised in a cycle that carries ack.
    wbi_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clear  (cmd_fire),
        .enable ((state == BUS) && !wbm_ack_i),
        .expire (tmo_expire)
    );
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_dat   <= '0;
            txn_count <= '0;
`ifdef WB_TEST_INITIATOR_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        // Payload is latched once and stays put for the
                        // whole bus cycle regardless of the command port.
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        state     <= BUS;
                    end
                end

                BUS: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
                        txn_count <= txn_count + 1'b1;
`ifdef WB_TEST_INITIATOR_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        state     <= RESP;
                    end
`ifdef WB_TEST_INITIATOR_TIMEOUT_EN
                    else if (tmo_expire) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= '0;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end
`endif
                end

                RESP: begin
                    // rsp_dat/rsp_err hold; acks arriving here are ignored.
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_test_initiator.sv
// -----------------------------------------------------------------------------
// tb_wb_test_initiator
// Directed bench for wb_test_initiator (TIMEOUT_CYCLES=8, CNT_W=3 so the
// transfer counter wrap is reachable). Timeout scenarios follow the
// WB_TEST_INITIATOR_TIMEOUT_EN build option.
// -----------------------------------------------------------------------------
module tb_wb_test_initiator;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic [2:0]  txn_count;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    int checks = 0;
    int errors = 0;
    int n;
    logic [2:0] exp_txn;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_test_initiator #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (3)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .txn_count (txn_count),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Present a command for exactly one edge (DUT is in IDLE, so it is taken).
    task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Read with ack in the first BUS cycle, then accept the response.
    task automatic quick_read(input logic [31:0] rdata);
        send(1'b0, 32'h3000_0100, 32'h0, 4'hF);
        wbm_ack_i = 1'b1; wbm_dat_i = rdata;
        tick();
        wbm_ack_i = 1'b0;
        chk("qr_rsp_dat", rsp_dat, rdata);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        wb_rst_i = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;

        // ---- reset state
        #2;
        chk("rst_cyc", wbm_cyc_o, 1'b0);
        chk("rst_stb", wbm_stb_o, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_dat", rsp_dat, 32'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_txn", txn_count, 3'd0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        tick(); tick();
        wb_rst_i = 1'b0;
        #1;
        chk("rel_cmd_ready", cmd_ready, 1'b1);

        // ---- write, ack on 3rd stb cycle
        send(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        chk("wr_cmd_ready", cmd_ready, 1'b0);
        n = 0;
        while (wbm_stb_o && n < 20) begin
            n++;
            chk("wr_cyc", wbm_cyc_o, 1'b1);
            chk("wr_we", wbm_we_o, 1'b1);
            chk("wr_adr", wbm_adr_o, 32'h3000_0004);
            chk("wr_dat", wbm_dat_o, 32'hDEAD_BEEF);
            chk("wr_sel", wbm_sel_o, 4'hF);
            wbm_ack_i = (n == 3);
            wbm_dat_i = 32'h5555_AAAA;
            tick();
            wbm_ack_i = 1'b0;
        end
        chk("wr_stb_cycles", n, 3);
        chk("wr_cyc_low", wbm_cyc_o, 1'b0);
        chk("wr_rsp_valid", rsp_valid, 1'b1);
        chk("wr_rsp_dat", rsp_dat, 32'h0);
        chk("wr_rsp_err", rsp_err, 1'b0);
        chk("wr_txn", txn_count, 3'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("wr_cmd_ready_after", cmd_ready, 1'b1);
        chk("wr_rsp_valid_after", rsp_valid, 1'b0);

        // ---- read, ack in first BUS cycle: response 2 edges after handshake
        send(1'b0, 32'h3000_0008, 32'h0, 4'h3);
        chk("rd_stb", wbm_stb_o, 1'b1);
        chk("rd_we", wbm_we_o, 1'b0);
        chk("rd_rsp_valid_early", rsp_valid, 1'b0);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678;
        tick();
        wbm_ack_i = 1'b0;
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_stb_low", wbm_stb_o, 1'b0);
        chk("rd_rsp_dat", rsp_dat, 32'h1234_5678);
        chk("rd_txn", txn_count, 3'd2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ---- backpressure with a stray ack and a pending command
        send(1'b0, 32'h3000_000C, 32'h0, 4'hF);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hA5A5_0001;
        tick();
        wbm_ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_dat", rsp_dat, 32'hA5A5_0001);
            chk("bp_cmd_ready", cmd_ready, 1'b0);
            chk("bp_stb", wbm_stb_o, 1'b0);
            wbm_ack_i = (i == 2); wbm_dat_i = 32'hFFFF_FFFF;
            tick();
            wbm_ack_i = 1'b0;
        end
        chk("bp_txn", txn_count, 3'd3);
        chk("bp_rsp_dat_end", rsp_dat, 32'hA5A5_0001);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_cmd_ready_after", cmd_ready, 1'b1);

`ifdef WB_TEST_INITIATOR_TIMEOUT_EN
        // ---- timeout: never ack
        send(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        n = 0;
        while (wbm_stb_o && n < 50) begin
            n++;
            tick();
        end
        chk("tmo_stb_cycles", n, 8);
        chk("tmo_rsp_valid", rsp_valid, 1'b1);
        chk("tmo_rsp_err", rsp_err, 1'b1);
        chk("tmo_rsp_dat", rsp_dat, 32'h0);
        chk("tmo_txn", txn_count, 3'd3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ---- ack in the 8th (expiring) cycle: ack wins
        send(1'b0, 32'h3000_0014, 32'h0, 4'hF);
        for (int i = 0; i < 7; i++) tick();
        chk("coin_stb", wbm_stb_o, 1'b1);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hCAFE_F00D;
        tick();
        wbm_ack_i = 1'b0;
        chk("coin_rsp_valid", rsp_valid, 1'b1);
        chk("coin_rsp_err", rsp_err, 1'b0);
        chk("coin_rsp_dat", rsp_dat, 32'hCAFE_F00D);
        chk("coin_txn", txn_count, 3'd4);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // start a command so the reset below hits mid-BUS
        send(1'b1, 32'h3000_0018, 32'h0000_0001, 4'h1);
`else
        // ---- no timeout: stb held for 300 cycles, no response; left in BUS
        send(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (wbm_stb_o && !rsp_valid) n++;
            tick();
        end
        chk("notmo_stb_cycles", n, 300);
        chk("notmo_stb", wbm_stb_o, 1'b1);
        chk("notmo_rsp_valid", rsp_valid, 1'b0);
        chk("notmo_rsp_err", rsp_err, 1'b0);
`endif

        // ---- async reset mid-BUS, between edges
        chk("ar_stb_before", wbm_stb_o, 1'b1);
        #2;
        wb_rst_i = 1'b1;
        #1;
        chk("ar_cyc_drop", wbm_cyc_o, 1'b0);
        chk("ar_stb_drop", wbm_stb_o, 1'b0);
        #2;
        wb_rst_i = 1'b0;
        #1;
        chk("ar_cmd_ready", cmd_ready, 1'b1);
        chk("ar_txn", txn_count, 3'd0);
        chk("ar_rsp_valid", rsp_valid, 1'b0);
        tick();
        chk("ar_idle_stb", wbm_stb_o, 1'b0);

        // ---- new command completes normally after reset (ack on 2nd cycle)
        send(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        tick();
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h0BAD_F00D;
        tick();
        wbm_ack_i = 1'b0;
        chk("post_rsp_valid", rsp_valid, 1'b1);
        chk("post_rsp_dat", rsp_dat, 32'h0BAD_F00D);
        chk("post_txn", txn_count, 3'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ---- counter wrap: 6 more -> 7, one more -> 0
        for (int i = 0; i < 6; i++) quick_read(32'h100 + i);
        exp_txn = 3'd7;
        chk("wrap_txn_max", txn_count, exp_txn);
        quick_read(32'h0000_0200);
        exp_txn = 3'd0;
        chk("wrap_txn_zero", txn_count, exp_txn);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_test_initiator.md
# wb_test_initiator

Wishbone classic single-transfer initiator: the bus-master end of the user-area Wishbone slave port. It turns a simple valid/ready command stream into one Wishbone read or write at a time, returns read data or an error on a response stream, and aborts hung cycles with a timeout. It sits inside the user project, alongside the test structures, so firmware-independent sequencers (LA- or IO-driven) can exercise Wishbone responders on the test chip.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles `wbm_stb_o` stays high awaiting ack; legal range 1..255.
- `CNT_W`, default 16: width of the completed-transaction counter.

- `wb_clk_i` in 1: clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when both valid and ready are high.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_adr` in 32: byte address.
- `cmd_dat` in 32: write data.
- `cmd_sel` in 4: byte selects.
- `rsp_valid` out 1: response present, held until accepted.
- `rsp_ready` in 1: response consumer ready.
- `rsp_dat` out 32: read data; 0 for writes and errors.
- `rsp_err` out 1: transfer timed out.
- `txn_count` out CNT_W: completed (acked) transfers, wraps.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1: Wishbone control.
- `wbm_sel_o` out 4; `wbm_adr_o` out 32; `wbm_dat_o` out 32: Wishbone payload.
- `wbm_ack_i` in 1; `wbm_dat_i` in 32: Wishbone response.

## Operation
- FSM with states IDLE, BUS, RESP; reset state is IDLE.
- IDLE: `cmd_ready`=1. On handshake, register `we`/`adr`/`dat`/`sel` onto the `wbm_*` outputs, clear the timeout counter, and go to BUS.
- BUS: `wbm_cyc_o` = `wbm_stb_o` = 1 and `cmd_ready`=0. The payload is stable for the whole cycle.
  - On `wbm_ack_i`: capture `wbm_dat_i` into `rsp_dat` (reads only, else 0), set `rsp_err`=0, increment `txn_count`, and go to RESP.
  - Otherwise the timeout counter increments. When it reaches `TIMEOUT_CYCLES` with no ack: set `rsp_dat`=0, `rsp_err`=1, leave `txn_count` unchanged, and go to RESP.
- RESP: `rsp_valid`=1 and `cmd_ready`=0. On `rsp_ready`, go to IDLE. `rsp_dat` and `rsp_err` are held until then.
- `wbm_ack_i` outside BUS is ignored.
- If ack arrives in the same cycle the timeout expires, ack wins and the transfer completes normally.
- `txn_count` wraps from 2^CNT_W-1 to 0.
- Reset values: every output is 0, except `cmd_ready`, which is 1 once reset deasserts (it is decoded from state).
- Reset mid-BUS drops `wbm_cyc_o`/`wbm_stb_o` asynchronously, and the pending command is discarded.

## Timing
- Command handshake at edge N: `wbm_cyc_o`/`wbm_stb_o` are high from N+1.
- Ack sampled at edge M: cyc/stb are low and `rsp_valid` is high from M+1. The minimum, with ack in the first BUS cycle, is 2 cycles from command to response.
- Timeout: stb stays high for exactly `TIMEOUT_CYCLES` cycles, then drops.
- Response accepted at edge R: `cmd_ready` is high from R+1. There is no back-to-back overlap, so maximum throughput is one transfer per 3 cycles.
- All outputs are registered except `cmd_ready` and `rsp_valid`, which are decoded directly from state.

## Configuration
- `WB_TEST_INITIATOR_TIMEOUT_EN`
  - Defined: the timeout logic operates as described.
  - Undefined: there is no counter; BUS waits for ack indefinitely, `rsp_err` is tied 0, and `TIMEOUT_CYCLES` is ignored.

## Structure
- Shared package `wb_test_pkg` holds:
  - the state typedef (IDLE/BUS/RESP);
  - the Wishbone width constants (address 32, data 32, select 4);
  - the default `TIMEOUT_CYCLES`.
- One sub-module, `wbi_timeout_ctr`, with clear, enable, and expire output. It is instantiated only under `WB_TEST_INITIATOR_TIMEOUT_EN`.

## Test plan
- Write: command we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; the slave acks on its 3rd stb cycle.
  - Bus sees exactly that payload for 3 cycles.
  - `rsp_valid` follows with rsp_dat=0, rsp_err=0, and txn_count=1.
- Read: slave returns 0x1234_5678 with ack in the first BUS cycle.
  - rsp_dat=0x1234_5678 arrives 2 cycles after the command handshake.
- Timeout with TIMEOUT_CYCLES=8: the slave never acks.
  - stb is high for exactly 8 cycles, then rsp_err=1, rsp_dat=0, and txn_count is unchanged.
  - With the macro undefined, stb stays high for at least 300 cycles and no response is produced.
- Ack coincident with the timeout edge: the response has rsp_err=0 and carries the captured data.
- Backpressure: rsp_ready is held low for 5 cycles.
  - rsp_valid and rsp_dat stay stable and cmd_ready stays 0.
  - A stray ack meanwhile has no effect.
- Async reset asserted mid-BUS, between clock edges:
  - cyc/stb drop immediately.
  - After release, cmd_ready=1 and txn_count=0.
  - A new command completes normally.
